cp0_regfile_gen: RTL and testbench
==================================

// Module: cp0_regfile_gen
// PURPOSE
//  Parametrised CP0 register file for the MIPS pipeline: BadVAddr, Count, Compare, Status,
//  Cause, EPC, PRId and Config. Adds a Count prescaler, a configurable hardware-interrupt
//  count, encoded ExcCode input, ERET handling, write masks and interrupt-request generation.
//  Written from MEM/WB (mtc0, exception commit); read from EX (mfc0).
// PARAMETERS
//  NUM_HW_INT  6             hardware interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2]
//  COUNT_DIV   2             clk cycles per Count increment (>=1)
//  PRID_VAL    32'h004C0102  PRId constant
//  CONFIG_VAL  32'h00008000  Config constant
// PORTS
//  clk         in   1           clock
//  rst         in   1           asynchronous, active-high reset
//  i_raddr     in   5           CP0 read address (mfc0)
//  o_rdata     out  32          read data, combinational
//  i_we        in   1           mtc0 write enable
//  i_waddr     in   5           mtc0 write address
//  i_wdata     in   32          mtc0 write data
//  i_hw_int    in   NUM_HW_INT  external interrupt levels
//  i_exc_valid in   1           exception commits this cycle
//  i_exc_code  in   5           ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 10 RI, 12 Ov, 13 Tr)
//  i_exc_pc    in   32          PC of faulting instruction
//  i_exc_bd    in   1           faulting instruction is in a delay slot
//  i_badvaddr  in   32          faulting address (AdEL/AdES)
//  i_eret      in   1           eret commits this cycle
//  o_status    out  32          Status register
//  o_cause     out  32          Cause register
//  o_epc       out  32          EPC register
//  o_timer_int out  1           sticky timer interrupt
//  o_int_req   out  1           interrupt request to the pipeline
// BEHAVIOUR
//  Addresses: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
//   Unmapped reads return 0. o_rdata shows pre-write register state (no same-cycle bypass).
//  Reset: BadVAddr=Count=Compare=Cause=EPC=0, Status=32'h10000000, o_timer_int=0,
//   prescaler=0, o_int_req=0.
//  Prescaler: counts 0..COUNT_DIV-1. Count increments (mod 2^32) on the cycle the prescaler
//   wraps. FFFFFFFF wraps to 0.
//  Timer: set o_timer_int (sticky) on the cycle Count increments to a value equal to a
//   nonzero Compare. An mtc0 to Compare clears it.
//  Cause.IP[7:2] re-registers every cycle: {hw ints, zero-padded to 6} with IP[7] ORed with
//   o_timer_int. Latency from i_hw_int to Cause: 1 cycle.
//  o_int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[15:8]), combinational
//   on registered state.
//  Write masks:
//   Status writable bits are [28], [15:8], [1:0]; all other bits hold.
//   Cause writable bits are [9:8] only.
//   EPC, Count and Compare are fully writable.
//   BadVAddr, PRId and Config are read-only; writes to them are ignored.
//  mtc0 Count: loads i_wdata and clears the prescaler. Overrides a same-cycle tick.
//  mtc0 Compare: clears the timer interrupt. Overrides a same-cycle match set.
//  Priority (same cycle): i_exc_valid > i_eret > i_we. A lower-priority action is dropped
//   entirely. Count tick and Cause.IP sampling always proceed.
//  Exception, when Status.EXL==0:
//   EPC = i_exc_bd ? i_exc_pc-4 : i_exc_pc.
//   Cause.BD = i_exc_bd.
//  Exception, when Status.EXL==1: EPC and BD hold.
//  Exception, always: EXL<=1; Cause[6:2]<=i_exc_code. If code is 4 or 5,
//   BadVAddr<=i_badvaddr.
//  ERET: Status.EXL<=0; all other registers unchanged.
//  Reset mid-operation forces all reset values immediately (asynchronous reset).
// TESTING
//  COUNT_DIV=2, reset, run 10 clk -> Count=5. mtc0 Count=FFFFFFFF, then 2 clk -> Count=0.
//  Compare=7, Count=5 -> o_timer_int=1 once Count reaches 7, stays 1 after Count=8.
//   mtc0 Compare -> o_timer_int=0 next cycle.
//  Status=32'h0000_0401, i_hw_int=6'b000001 -> Cause.IP[2]=1 after 1 clk, o_int_req=1.
//   Set EXL -> o_int_req=0.
//  exc_code=4, pc=0x80, bd=1, badvaddr=0x1003 -> EPC=0x7C, BD=1, ExcCode=4, EXL=1,
//   BadVAddr=0x1003. Second exception with pc=0x200 -> EPC stays 0x7C. eret -> EXL=0.
//  Same-cycle i_exc_valid and mtc0 EPC=0x1234 -> EPC takes the exception value.
//   mtc0 Cause=FFFFFFFF -> only bits [9:8] change.
//  Assert rst mid-count (Count=0x33) -> all regs at reset values with no clk edge.

Source files
------------

// File: rtl/cp0_regfile_gen.sv
// CP0 register file: BadVAddr, Count/Compare timer with prescaler, Status, Cause, EPC,
// PRId and Config. Written from MEM/WB (mtc0, exception/eret commit), read from EX (mfc0).
module cp0_regfile_gen #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            i_raddr,
  output logic [31:0]           o_rdata,
  input  logic                  i_we,
  input  logic [4:0]            i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [NUM_HW_INT-1:0] i_hw_int,
  input  logic                  i_exc_valid,
  input  logic [4:0]            i_exc_code,
  input  logic [31:0]           i_exc_pc,
  input  logic                  i_exc_bd,
  input  logic [31:0]           i_badvaddr,
  input  logic                  i_eret,
  output logic [31:0]           o_status,
  output logic [31:0]           o_cause,
  output logic [31:0]           o_epc,
  output logic                  o_timer_int,
  output logic                  o_int_req
);

  localparam int            PW           = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(COUNT_DIV - 1);
  localparam logic [31:0]   STATUS_RST   = 32'h1000_0000;
  localparam logic [31:0]   STATUS_WMASK = 32'h1000_FF03;

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;
  localparam logic [4:0] A_CONFIG   = 5'd16;

  logic [31:0]   badvaddr_q, count_q, compare_q, status_q, cause_q, epc_q;
  logic [PW-1:0] presc_q;
  logic          timer_q;

  logic        wr_ok, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        tick, timer_match, exl, bad_addr_exc;
  logic [31:0] count_inc;
  logic [5:0]  ip_next;

  // An exception or eret in the same cycle drops the mtc0 completely.
  assign wr_ok      = i_we & ~i_exc_valid & ~i_eret;
  assign wr_count   = wr_ok & (i_waddr == A_COUNT);
  assign wr_compare = wr_ok & (i_waddr == A_COMPARE);
  assign wr_status  = wr_ok & (i_waddr == A_STATUS);
  assign wr_cause   = wr_ok & (i_waddr == A_CAUSE);
  assign wr_epc     = wr_ok & (i_waddr == A_EPC);

  assign exl          = status_q[1];
  assign tick         = (presc_q == PRESC_MAX);
  assign count_inc    = count_q + 32'd1;
  assign timer_match  = tick & ~wr_count & (count_inc == compare_q) & (compare_q != 32'd0);
  assign bad_addr_exc = (i_exc_code == 5'd4) | (i_exc_code == 5'd5);

  always_comb begin
    ip_next                 = 6'd0;
    ip_next[NUM_HW_INT-1:0] = i_hw_int;
    ip_next[5]              = ip_next[5] | timer_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           presc_q <= '0;
    else if (wr_count) presc_q <= '0;
    else if (tick)     presc_q <= '0;
    else               presc_q <= presc_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count_q <= 32'd0;
    else if (wr_count) count_q <= i_wdata;
    else if (tick)     count_q <= count_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             compare_q <= 32'd0;
    else if (wr_compare) compare_q <= i_wdata;
  end

  // Sticky until software rewrites Compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              timer_q <= 1'b0;
    else if (wr_compare)  timer_q <= 1'b0;
    else if (timer_match) timer_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              status_q    <= STATUS_RST;
    else if (i_exc_valid) status_q[1] <= 1'b1;
    else if (i_eret)      status_q[1] <= 1'b0;
    else if (wr_status)   status_q    <= (status_q & ~STATUS_WMASK) | (i_wdata & STATUS_WMASK);
  end

  // IP[7:2] are resampled every cycle regardless of any commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= 32'd0;
    end else begin
      cause_q[15:10] <= ip_next;
      if (i_exc_valid) begin
        cause_q[6:2] <= i_exc_code;
        if (!exl) cause_q[31] <= i_exc_bd;
      end else if (wr_cause) begin
        cause_q[9:8] <= i_wdata[9:8];
      end
    end
  end

  // Nested exceptions keep the original return address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    epc_q <= 32'd0;
    else if (i_exc_valid) begin
      if (!exl)                 epc_q <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
    end else if (wr_epc)        epc_q <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               badvaddr_q <= 32'd0;
    else if (i_exc_valid && bad_addr_exc)  badvaddr_q <= i_badvaddr;
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_raddr)
      A_BADVADDR: o_rdata = badvaddr_q;
      A_COUNT:    o_rdata = count_q;
      A_COMPARE:  o_rdata = compare_q;
      A_STATUS:   o_rdata = status_q;
      A_CAUSE:    o_rdata = cause_q;
      A_EPC:      o_rdata = epc_q;
      A_PRID:     o_rdata = PRID_VAL;
      A_CONFIG:   o_rdata = CONFIG_VAL;
      default:    o_rdata = 32'd0;
    endcase
  end

  assign o_status    = status_q;
  assign o_cause     = cause_q;
  assign o_epc       = epc_q;
  assign o_timer_int = timer_q;
  assign o_int_req   = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile_gen.sv
// Bench for cp0_regfile_gen: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a register-level model of the CP0 rules.
module tb_cp0_regfile_gen;

  localparam int NUM_HW_INT = 6;
  localparam int COUNT_DIV  = 2;
  localparam logic [31:0] PRID_VAL   = 32'h004C0102;
  localparam logic [31:0] CONFIG_VAL = 32'h00008000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]            i_raddr = '0;
  logic [31:0]           o_rdata;
  logic                  i_we = 1'b0;
  logic [4:0]            i_waddr = '0;
  logic [31:0]           i_wdata = '0;
  logic [NUM_HW_INT-1:0] i_hw_int = '0;
  logic                  i_exc_valid = 1'b0;
  logic [4:0]            i_exc_code = '0;
  logic [31:0]           i_exc_pc = '0;
  logic                  i_exc_bd = 1'b0;
  logic [31:0]           i_badvaddr = '0;
  logic                  i_eret = 1'b0;
  logic [31:0]           o_status, o_cause, o_epc;
  logic                  o_timer_int, o_int_req;

  cp0_regfile_gen #(
    .NUM_HW_INT(NUM_HW_INT), .COUNT_DIV(COUNT_DIV),
    .PRID_VAL(PRID_VAL), .CONFIG_VAL(CONFIG_VAL)
  ) dut (
    .clk(clk), .rst(rst), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_hw_int(i_hw_int),
    .i_exc_valid(i_exc_valid), .i_exc_code(i_exc_code), .i_exc_pc(i_exc_pc),
    .i_exc_bd(i_exc_bd), .i_badvaddr(i_badvaddr), .i_eret(i_eret),
    .o_status(o_status), .o_cause(o_cause), .o_epc(o_epc),
    .o_timer_int(o_timer_int), .o_int_req(o_int_req)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;
  int          m_cycles;  // clocks since Count was last reset or written

  function automatic void model_reset();
    m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0; m_cause = 0;
    m_status = 32'h1000_0000; m_timer = 1'b0; m_cycles = 0;
  endfunction

  function automatic void model_step();
    logic       old_timer;
    logic       do_write, count_write, inc;
    logic [5:0] hw6;
    old_timer   = m_timer;
    do_write    = i_we && !i_exc_valid && !i_eret;
    count_write = do_write && (i_waddr == 5'd9);
    m_cycles++;
    inc = !count_write && (m_cycles % COUNT_DIV == 0);
    if (inc) begin
      m_count = m_count + 1;
      if (m_compare != 0 && m_count == m_compare) m_timer = 1'b1;
    end
    hw6 = '0;
    hw6[NUM_HW_INT-1:0] = i_hw_int;
    hw6[5] = hw6[5] | old_timer;
    m_cause[15:10] = hw6;
    if (i_exc_valid) begin
      if (!m_status[1]) begin
        m_epc = i_exc_bd ? i_exc_pc - 4 : i_exc_pc;
        m_cause[31] = i_exc_bd;
      end
      m_status[1] = 1'b1;
      m_cause[6:2] = i_exc_code;
      if (i_exc_code == 4 || i_exc_code == 5) m_badv = i_badvaddr;
    end else if (i_eret) begin
      m_status[1] = 1'b0;
    end else if (do_write) begin
      case (i_waddr)
        5'd9:  begin m_count = i_wdata; m_cycles = 0; end
        5'd11: begin m_compare = i_wdata; m_timer = 1'b0; end
        5'd12: m_status = (m_status & ~32'h1000_FF03) | (i_wdata & 32'h1000_FF03);
        5'd13: m_cause[9:8] = i_wdata[9:8];
        5'd14: m_epc = i_wdata;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] model_rdata(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID_VAL;
      5'd16: return CONFIG_VAL;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata",    o_rdata, model_rdata(i_raddr));
      check("status",   o_status, m_status);
      check("cause",    o_cause, m_cause);
      check("epc",      o_epc, m_epc);
      check("timer_int", 32'(o_timer_int), 32'(m_timer));
      check("int_req",  32'(o_int_req),
            32'(m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 0)));
    end
  end

  // ---------------- driver tasks (all run from posedge+1) ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    i_we = 1'b1; i_waddr = a; i_wdata = d;
    step(1);
    i_we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic [31:0] bva);
    i_exc_valid = 1'b1; i_exc_code = code; i_exc_pc = pc; i_exc_bd = bd; i_badvaddr = bva;
    step(1);
    i_exc_valid = 1'b0;
  endtask

  task automatic eret();
    i_eret = 1'b1;
    step(1);
    i_eret = 1'b0;
  endtask

  task automatic read(input logic [4:0] a, output logic [31:0] d);
    i_raddr = a;
    #1;
    d = o_rdata;
  endtask

  // DUT and model both pinned to a hand-computed value.
  task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] lit);
    check({name, "_dut"}, dut_v, lit);
    check({name, "_model"}, mdl_v, lit);
  endtask

  int codes[7] = '{0, 4, 5, 8, 10, 12, 13};
  int waddrs[10] = '{8, 9, 11, 12, 13, 14, 15, 16, 3, 31};

  initial begin
    logic [31:0] r;
    #12;
    read(5'd9, r);
    pin("rst_count", r, m_count, 32'h0);
    pin("rst_status", o_status, m_status, 32'h1000_0000);
    pin("rst_cause", o_cause, m_cause, 32'h0);
    pin("rst_epc", o_epc, m_epc, 32'h0);
    check("rst_timer", 32'(o_timer_int), 32'h0);
    check("rst_int_req", 32'(o_int_req), 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Prescaler: 10 clocks at divide-by-2 gives Count=5, then wrap from all-ones.
    step(10);
    read(5'd9, r);
    pin("count_10clk", r, m_count, 32'd5);
    mtc0(5'd9, 32'hFFFF_FFFF);
    step(2);
    read(5'd9, r);
    pin("count_wrap", r, m_count, 32'd0);

    // Timer match and Compare write clears it.
    mtc0(5'd11, 32'd7);
    mtc0(5'd9, 32'd5);
    step(4);
    read(5'd9, r);
    pin("count_at_7", r, m_count, 32'd7);
    pin("timer_set", 32'(o_timer_int), 32'(m_timer), 32'd1);
    step(2);
    read(5'd9, r);
    check("count_at_8", r, 32'd8);
    pin("timer_sticky", 32'(o_timer_int), 32'(m_timer), 32'd1);
    mtc0(5'd11, 32'd0);
    pin("timer_clear", 32'(o_timer_int), 32'(m_timer), 32'd0);
    step(1);

    // Hardware interrupt request path.
    i_hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    pin("status_ie_im2", o_status, m_status, 32'h0000_0401);
    check("cause_ip2", 32'(o_cause[10]), 32'd1);
    check("int_req_on", 32'(o_int_req), 32'd1);
    mtc0(5'd12, 32'h0000_0403);
    check("int_req_exl", 32'(o_int_req), 32'd0);
    mtc0(5'd12, 32'h0000_0401);
    i_hw_int = '0;
    step(1);

    // Exception in a delay slot, then nested exception, then eret.
    exc(5'd4, 32'h80, 1'b1, 32'h1003);
    pin("exc_epc", o_epc, m_epc, 32'h7C);
    check("exc_bd", 32'(o_cause[31]), 32'd1);
    check("exc_code", 32'(o_cause[6:2]), 32'd4);
    check("exc_exl", 32'(o_status[1]), 32'd1);
    read(5'd8, r);
    pin("exc_badv", r, m_badv, 32'h1003);
    exc(5'd12, 32'h200, 1'b0, 32'h5555);
    pin("nested_epc", o_epc, m_epc, 32'h7C);
    read(5'd8, r);
    check("nested_badv", r, 32'h1003);
    eret();
    check("eret_exl", 32'(o_status[1]), 32'd0);

    // Exception wins over a same-cycle mtc0 EPC; Cause write mask.
    i_we = 1'b1; i_waddr = 5'd14; i_wdata = 32'h1234;
    exc(5'd8, 32'h300, 1'b0, 32'h0);
    i_we = 1'b0;
    pin("exc_over_mtc0", o_epc, m_epc, 32'h300);
    eret();
    mtc0(5'd13, 32'hFFFF_FFFF);
    pin("cause_mask", o_cause, m_cause, 32'h0000_0320);
    read(5'd15, r);
    check("prid", r, PRID_VAL);
    read(5'd16, r);
    check("config", r, CONFIG_VAL);

    // Asynchronous reset mid-count, checked before any clock edge.
    mtc0(5'd9, 32'h33);
    read(5'd9, r);
    check("count_33", r, 32'h33);
    rst = 1'b1;
    #1;
    read(5'd9, r);
    pin("async_count", r, m_count, 32'h0);
    pin("async_status", o_status, m_status, 32'h1000_0000);
    check("async_cause", o_cause, 32'h0);
    check("async_epc", o_epc, 32'h0);
    check("async_timer", 32'(o_timer_int), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      i_raddr     = 5'($urandom_range(0, 31));
      i_hw_int    = NUM_HW_INT'($urandom);
      i_we        = ($urandom_range(0, 2) == 0);
      i_waddr     = 5'(waddrs[$urandom_range(0, 9)]);
      i_wdata     = $urandom;
      if (i_waddr == 5'd11 && $urandom_range(0, 1) == 1) i_wdata = m_count + $urandom_range(1, 6);
      if (i_waddr == 5'd9 && $urandom_range(0, 3) == 0) i_wdata = 32'hFFFF_FFFE;
      i_exc_valid = ($urandom_range(0, 15) == 0);
      i_exc_code  = 5'(codes[$urandom_range(0, 6)]);
      i_exc_pc    = $urandom & 32'hFFFF_FFFC;
      i_exc_bd    = 1'($urandom);
      i_badvaddr  = $urandom;
      i_eret      = ($urandom_range(0, 11) == 0);
      step(1);
    end
    i_we = 1'b0; i_exc_valid = 1'b0; i_eret = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
